// File: rtl/rx_shift_logic_if.sv
// Serial receive bus between the SSP pins and the rx_shift_logic word assembler.
// RxOverrun exists only when SSP_RX_OVERRUN_EN is defined.
interface rx_shift_logic_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  SSPCLKIN;
  logic                  SSPFSSIN;
  logic                  SSPRXD;
  logic                  SSPRXINTR;
  logic [DATA_WIDTH-1:0] RxData;
  logic                  NextWord;
  logic                  RxBusy;
`ifdef SSP_RX_OVERRUN_EN
  logic                  RxOverrun;

  modport slave (
    input  SSPCLKIN, SSPFSSIN, SSPRXD, SSPRXINTR,
    output RxData, NextWord, RxBusy, RxOverrun
  );

  modport master (
    output SSPCLKIN, SSPFSSIN, SSPRXD, SSPRXINTR,
    input  RxData, NextWord, RxBusy, RxOverrun
  );
`else
  modport slave (
    input  SSPCLKIN, SSPFSSIN, SSPRXD, SSPRXINTR,
    output RxData, NextWord, RxBusy
  );

  modport master (
    output SSPCLKIN, SSPFSSIN, SSPRXD, SSPRXINTR,
    input  RxData, NextWord, RxBusy
  );
`endif
endinterface

// File: rtl/rx_shift_logic.sv
// SSP receive serial-to-parallel stage: MSB-first frames into words with a NextWord strobe.
// Define SSP_RX_OVERRUN_EN to drop words while the FIFO is full and raise a sticky RxOverrun.
module rx_shift_logic #(
  parameter int DATA_WIDTH = 8
) (
  input  logic              PCLK,
  input  logic              CLEAR_B,
  rx_shift_logic_if.slave   bus
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_stateNext;
  logic                  r_clkQ;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_rxData;
  logic                  r_nextWord;
  logic                  w_sample;
  logic                  w_lastBit;
  logic                  w_drop;
  logic [DATA_WIDTH-1:0] w_word;

  // A sample event is a rising SSPCLKIN seen through one PCLK of history.
  assign w_sample  = bus.SSPCLKIN & ~r_clkQ;
  assign w_lastBit = (r_state == SHIFT) && w_sample && (r_cnt == LAST_CNT);
  assign w_word    = {r_shift[DATA_WIDTH-2:0], bus.SSPRXD};

`ifdef SSP_RX_OVERRUN_EN
  logic r_overrun;

  assign w_drop = w_lastBit & bus.SSPRXINTR;

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end
  end

  assign bus.RxOverrun = r_overrun;
`else
  logic w_unusedIntr;

  assign w_drop       = 1'b0;
  assign w_unusedIntr = bus.SSPRXINTR;
`endif

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: begin
        if (w_sample && bus.SSPFSSIN) begin
          w_stateNext = SHIFT;
        end
      end
      SHIFT: begin
        // FSS on the final bit chains straight into the next frame.
        if (w_lastBit && !bus.SSPFSSIN) begin
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      r_clkQ     <= 1'b0;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_rxData   <= '0;
      r_nextWord <= 1'b0;
    end else begin
      r_clkQ     <= bus.SSPCLKIN;
      r_nextWord <= 1'b0;
      if (w_sample) begin
        if (r_state == IDLE) begin
          if (bus.SSPFSSIN) begin
            r_cnt <= '0;
          end
        end else begin
          r_shift <= w_word;
          if (w_lastBit) begin
            r_cnt <= '0;
            if (!w_drop) begin
              r_rxData   <= w_word;
              r_nextWord <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign bus.RxData   = r_rxData;
  assign bus.NextWord = r_nextWord;
  assign bus.RxBusy   = (r_state == SHIFT);

endmodule

// File: tb/tb_rx_shift_logic.sv
// Directed bench for rx_shift_logic with a queue-based frame model checked every PCLK.
// Build with SSP_RX_OVERRUN_EN defined to exercise the overrun variant.
module tb_rx_shift_logic;

  localparam int DW = 8;

  logic PCLK;
  logic CLEAR_B;

  rx_shift_logic_if #(.DATA_WIDTH(DW)) bus ();

  rx_shift_logic #(.DATA_WIDTH(DW)) dut (
    .PCLK    (PCLK),
    .CLEAR_B (CLEAR_B),
    .bus     (bus.slave)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int checks = 0;
  int passes = 0;

  // Model state: frame activity and the bits collected so far, MSB first.
  bit          mBusy    = 1'b0;
  bit          mNext    = 1'b0;
  logic [DW-1:0] mData  = '0;
  bit          mOverrun = 1'b0;
  bit          mPrevClk = 1'b0;
  bit          mBits[$];

  int cycle      = 0;
  int pulseCount = 0;
  int busyCount  = 0;
  int pulseCycles[$];
  logic [DW-1:0] pulseWords[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Model: on every rising serial clock, collect bits into a queue; a full queue is one word.
  always @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      mBusy    = 1'b0;
      mNext    = 1'b0;
      mData    = '0;
      mOverrun = 1'b0;
      mPrevClk = 1'b0;
      mBits.delete();
    end else begin
      mNext = 1'b0;
      if (bus.SSPCLKIN && !mPrevClk) begin
        if (!mBusy) begin
          if (bus.SSPFSSIN) begin
            mBusy = 1'b1;
            mBits.delete();
          end
        end else begin
          mBits.push_back(bus.SSPRXD);
          if (mBits.size() == DW) begin
            logic [DW-1:0] w;
            w = '0;
            for (int i = 0; i < DW; i++) w[DW-1-i] = mBits[i];
`ifdef SSP_RX_OVERRUN_EN
            if (bus.SSPRXINTR) begin
              mOverrun = 1'b1;
            end else begin
              mNext = 1'b1;
              mData = w;
            end
`else
            mNext = 1'b1;
            mData = w;
`endif
            mBusy = bus.SSPFSSIN;
            mBits.delete();
          end
        end
      end
      mPrevClk = bus.SSPCLKIN;
    end
  end

  // Per-cycle comparison against the model, plus activity counters for the literal checks.
  always @(posedge PCLK) begin
    #1;
    cycle++;
    checkOutput("NextWord", 32'(bus.NextWord), 32'(mNext));
    checkOutput("RxData",   32'(bus.RxData),   32'(mData));
    checkOutput("RxBusy",   32'(bus.RxBusy),   32'(mBusy));
`ifdef SSP_RX_OVERRUN_EN
    checkOutput("RxOverrun", 32'(bus.RxOverrun), 32'(mOverrun));
`endif
    if (bus.NextWord) begin
      pulseCount++;
      pulseCycles.push_back(cycle);
      pulseWords.push_back(bus.RxData);
    end
    if (bus.RxBusy) busyCount++;
  end

  // One serial bit: SSPCLKIN low for one PCLK, then high for one PCLK.
  task automatic applyStimulus(input bit fss, input bit d);
    @(negedge PCLK);
    bus.SSPCLKIN = 1'b0;
    bus.SSPFSSIN = fss;
    bus.SSPRXD   = d;
    @(negedge PCLK);
    bus.SSPCLKIN = 1'b1;
  endtask

  task automatic idleBits(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
  endtask

  // fssAt = index of the data bit (0 = MSB) carrying FSS, or -1 for none.
  task automatic sendFrame(input logic [DW-1:0] w, input bit lead, input int fssAt);
    if (lead) applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < DW; i++) applyStimulus(i == fssAt, w[DW-1-i]);
  endtask

  task automatic clearCounters();
    pulseCount = 0;
    busyCount  = 0;
    pulseCycles.delete();
    pulseWords.delete();
  endtask

  task automatic doReset();
    @(negedge PCLK);
    CLEAR_B = 1'b0;
    repeat (3) @(negedge PCLK);
    CLEAR_B = 1'b1;
  endtask

  initial begin
    CLEAR_B       = 1'b0;
    bus.SSPCLKIN  = 1'b0;
    bus.SSPFSSIN  = 1'b0;
    bus.SSPRXD    = 1'b0;
    bus.SSPRXINTR = 1'b0;
    repeat (3) @(negedge PCLK);
    checkOutput("resetRxData",   32'(bus.RxData),   32'h0);
    checkOutput("resetNextWord", 32'(bus.NextWord), 32'h0);
    checkOutput("resetRxBusy",   32'(bus.RxBusy),   32'h0);
    CLEAR_B = 1'b1;
    idleBits(2);

    // Single frame
    clearCounters();
    sendFrame(8'hE7, 1'b1, -1);
    idleBits(2);
    checkOutput("singlePulses", 32'(pulseCount), 32'd1);
    checkOutput("singleData",   32'(bus.RxData), 32'hE7);
    checkOutput("singleBusy",   32'(busyCount),  32'd16);

    // Three isolated frames
    clearCounters();
    sendFrame(8'hE7, 1'b1, -1);
    idleBits(3);
    sendFrame(8'h3A, 1'b1, -1);
    idleBits(3);
    checkOutput("holdData", 32'(bus.RxData), 32'h3A);
    sendFrame(8'h29, 1'b1, -1);
    idleBits(2);
    checkOutput("threePulses", 32'(pulseCount), 32'd3);
    if (pulseWords.size() == 3) begin
      checkOutput("threeWord0", 32'(pulseWords[0]), 32'hE7);
      checkOutput("threeWord1", 32'(pulseWords[1]), 32'h3A);
      checkOutput("threeWord2", 32'(pulseWords[2]), 32'h29);
    end

    // Back-to-back frames
    clearCounters();
    sendFrame(8'hA5, 1'b1, DW - 1);
    sendFrame(8'h5A, 1'b0, -1);
    idleBits(2);
    checkOutput("b2bPulses", 32'(pulseCount), 32'd2);
    checkOutput("b2bBusy",   32'(busyCount),  32'd32);
    if (pulseCycles.size() == 2) begin
      checkOutput("b2bSpacing", 32'(pulseCycles[1] - pulseCycles[0]), 32'd16);
      checkOutput("b2bWord0",   32'(pulseWords[0]), 32'hA5);
      checkOutput("b2bWord1",   32'(pulseWords[1]), 32'h5A);
    end

    // Mid-frame reset
    clearCounters();
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1);
    doReset();
    checkOutput("rstData", 32'(bus.RxData), 32'h0);
    checkOutput("rstBusy", 32'(bus.RxBusy), 32'h0);
    idleBits(4);
    checkOutput("rstNoPulse", 32'(pulseCount), 32'd0);
    sendFrame(8'h81, 1'b1, -1);
    idleBits(2);
    checkOutput("rstPulses", 32'(pulseCount), 32'd1);
    checkOutput("rstAfter",  32'(bus.RxData), 32'h81);

    // FSS during bit 3 is ignored
    clearCounters();
    sendFrame(8'h0F, 1'b1, 3);
    idleBits(2);
    checkOutput("fssPulses", 32'(pulseCount), 32'd1);
    checkOutput("fssData",   32'(bus.RxData), 32'h0F);
    checkOutput("fssBusy",   32'(busyCount),  32'd16);

    // FIFO-full at completion
    sendFrame(8'h29, 1'b1, -1);
    idleBits(2);
    clearCounters();
    bus.SSPRXINTR = 1'b1;
    sendFrame(8'hC3, 1'b1, -1);
    idleBits(1);
    bus.SSPRXINTR = 1'b0;
    idleBits(1);
`ifdef SSP_RX_OVERRUN_EN
    checkOutput("ovrNoPulse", 32'(pulseCount),    32'd0);
    checkOutput("ovrData",    32'(bus.RxData),    32'h29);
    checkOutput("ovrFlag",    32'(bus.RxOverrun), 32'h1);
    sendFrame(8'h3A, 1'b1, -1);
    idleBits(2);
    checkOutput("ovrLaterData", 32'(bus.RxData),    32'h3A);
    checkOutput("ovrSticky",    32'(bus.RxOverrun), 32'h1);
    doReset();
    checkOutput("ovrCleared",   32'(bus.RxOverrun), 32'h0);
`else
    checkOutput("fullPulses", 32'(pulseCount), 32'd1);
    checkOutput("fullData",   32'(bus.RxData), 32'hC3);
`endif
    idleBits(2);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
